// File: rtl/acsp_pkg.sv
// Shared definitions for the acquisition sample path: word-flag position,
// run-length limit helper and the RLE word kinds.
package acsp_pkg;

  localparam int RLE_SAMPLE_WIDTH = 8;
  localparam int RLE_FLAG_BIT     = RLE_SAMPLE_WIDTH - 1;

  typedef enum logic {
    RLE_VALUE = 1'b0,
    RLE_COUNT = 1'b1
  } rle_word_t;

  function automatic int rle_maxc(input int width);
    return (32'sd1 <<< (width - 32'sd1)) - 32'sd1;
  endfunction

endpackage

// File: rtl/rle_run_counter.sv
// Saturating repeat counter for the run-length encoder: clear, load-1 and
// increment controls, with a flag raised when the count is at its maximum.
module rle_run_counter
  import acsp_pkg::*;
#(
  parameter int CW = 7
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          load1,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_next,
  output logic          sat
);

  localparam logic [CW-1:0] MAXC = CW'(rle_maxc(CW + 1));
  localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;

  // next count: clear beats load-1 beats increment; increment stops at MAXC
  always_comb begin
    cnt_next_s = cnt_r;
    if (clr) begin
      cnt_next_s = {CW{1'b0}};
    end else if (load1) begin
      cnt_next_s = ONE;
    end else if (inc && (cnt_r != MAXC)) begin
      cnt_next_s = cnt_r + ONE;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // count register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  assign cnt      = cnt_r;
  assign cnt_next = cnt_next_s;
  assign sat      = (cnt_r == MAXC);

endmodule

// File: rtl/rle_encoder.sv
// Run-length encoder between sampler and sample_fifo (value word + count words,
// or registered pass-through). Define RLE_STATS_EN to build the stat counters.
module rle_encoder
  import acsp_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    flush,
  input  logic [SAMPLE_WIDTH-1:0] data_in,
  input  logic                    valid_in,
  output logic [SAMPLE_WIDTH-1:0] data_out,
  output logic                    valid_out,
  output logic                    busy,
  output logic [31:0]             stat_in,
  output logic [31:0]             stat_out
);

  localparam int CW = SAMPLE_WIDTH - 1;
  localparam logic [CW-1:0] MAXC = CW'(rle_maxc(SAMPLE_WIDTH));
  localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

  function automatic logic [SAMPLE_WIDTH-1:0] mk_word(input rle_word_t kind, input logic [CW-1:0] payload);
    logic [SAMPLE_WIDTH-1:0] w;
    case (kind)
      RLE_VALUE: w = {1'b0, payload};
      RLE_COUNT: w = {1'b1, payload};
      default:   w = {1'b0, payload};
    endcase
    return w;
  endfunction

  logic [CW-1:0]           last_r, last_s;
  logic                    last_valid_r, last_valid_s;
  logic [SAMPLE_WIDTH-1:0] pend_r, pend_s;
  logic                    pend_valid_r, pend_valid_s;
  logic                    flush_pend_r, flush_pend_s;
  logic [SAMPLE_WIDTH-1:0] data_out_r, out_word_s;
  logic                    valid_out_r, out_valid_s;
  logic                    busy_r;
  logic                    prim_valid_s, sec_valid_s;
  logic [SAMPLE_WIDTH-1:0] prim_word_s, sec_word_s;
  logic                    cnt_clr_s, cnt_load1_s, cnt_inc_s;
  logic [CW-1:0]           cnt_s, cnt_next_s, cnt_after_s;
  logic                    sat_s;
  logic [CW-1:0]           sample_low_s;

  assign sample_low_s = data_in[CW-1:0];

  rle_run_counter #(.CW(CW)) u_run_counter (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr      (cnt_clr_s),
    .load1    (cnt_load1_s),
    .inc      (cnt_inc_s),
    .cnt      (cnt_s),
    .cnt_next (cnt_next_s),
    .sat      (sat_s)
  );

  // sample path classification, pend arbitration and flush servicing
  always_comb begin
    last_s       = last_r;
    last_valid_s = last_valid_r;
    pend_s       = pend_r;
    pend_valid_s = pend_valid_r;
    flush_pend_s = flush_pend_r;
    out_word_s   = data_out_r;
    out_valid_s  = 1'b0;
    prim_valid_s = 1'b0;
    prim_word_s  = {SAMPLE_WIDTH{1'b0}};
    sec_valid_s  = 1'b0;
    sec_word_s   = {SAMPLE_WIDTH{1'b0}};
    cnt_clr_s    = 1'b0;
    cnt_load1_s  = 1'b0;
    cnt_inc_s    = 1'b0;
    cnt_after_s  = cnt_s;
    if (enable) begin
      flush_pend_s = flush_pend_r | flush;
      if (valid_in) begin
        if (!last_valid_r) begin
          prim_valid_s = 1'b1;
          prim_word_s  = mk_word(RLE_VALUE, sample_low_s);
          last_s       = sample_low_s;
          last_valid_s = 1'b1;
          cnt_clr_s    = 1'b1;
        end else if (sample_low_s == last_r) begin
          if (sat_s) begin
            prim_valid_s = 1'b1;
            prim_word_s  = mk_word(RLE_COUNT, MAXC);
            cnt_load1_s  = 1'b1;
          end else begin
            cnt_inc_s   = 1'b1;
            cnt_after_s = cnt_s + ONE;
          end
        end else if (cnt_s == {CW{1'b0}}) begin
          prim_valid_s = 1'b1;
          prim_word_s  = mk_word(RLE_VALUE, sample_low_s);
          last_s       = sample_low_s;
        end else begin
          // count closes the old run now; the new value follows via pend
          prim_valid_s = 1'b1;
          prim_word_s  = mk_word(RLE_COUNT, cnt_s);
          sec_valid_s  = 1'b1;
          sec_word_s   = mk_word(RLE_VALUE, sample_low_s);
          last_s       = sample_low_s;
          cnt_clr_s    = 1'b1;
        end
      end else begin
        cnt_inc_s = 1'b0;
      end
      if (prim_valid_s) begin
        out_valid_s = 1'b1;
        if (pend_valid_r) begin
          out_word_s   = pend_r;
          pend_s       = prim_word_s;
          pend_valid_s = 1'b1;
        end else begin
          out_word_s   = prim_word_s;
          pend_s       = sec_word_s;
          pend_valid_s = sec_valid_s;
        end
      end else if (pend_valid_r) begin
        out_valid_s  = 1'b1;
        out_word_s   = pend_r;
        pend_valid_s = 1'b0;
      end else if (flush_pend_r) begin
        if (cnt_after_s != {CW{1'b0}}) begin
          out_valid_s = 1'b1;
          out_word_s  = mk_word(RLE_COUNT, cnt_after_s);
        end else begin
          out_valid_s = 1'b0;
        end
        cnt_clr_s    = 1'b1;
        last_valid_s = 1'b0;
        flush_pend_s = flush;
      end else begin
        out_valid_s = 1'b0;
      end
    end else begin
      out_valid_s  = valid_in;
      out_word_s   = data_in;
      cnt_clr_s    = 1'b1;
      last_valid_s = 1'b0;
      pend_valid_s = 1'b0;
      flush_pend_s = 1'b0;
    end
  end

  // encoder state and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_r       <= {CW{1'b0}};
      last_valid_r <= 1'b0;
      pend_r       <= {SAMPLE_WIDTH{1'b0}};
      pend_valid_r <= 1'b0;
      flush_pend_r <= 1'b0;
      data_out_r   <= {SAMPLE_WIDTH{1'b0}};
      valid_out_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      last_r       <= last_s;
      last_valid_r <= last_valid_s;
      pend_r       <= pend_s;
      pend_valid_r <= pend_valid_s;
      flush_pend_r <= flush_pend_s;
      data_out_r   <= out_word_s;
      valid_out_r  <= out_valid_s;
      busy_r       <= pend_valid_s | flush_pend_s | (cnt_next_s != {CW{1'b0}});
    end
  end

  assign data_out  = data_out_r;
  assign valid_out = valid_out_r;
  assign busy      = busy_r;

`ifdef RLE_STATS_EN
  logic [31:0] stat_in_r;
  logic [31:0] stat_out_r;

  // sample and emitted-word tallies, wrapping naturally
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_in_r  <= 32'd0;
      stat_out_r <= 32'd0;
    end else begin
      if (valid_in) begin
        stat_in_r <= stat_in_r + 32'd1;
      end
      if (out_valid_s) begin
        stat_out_r <= stat_out_r + 32'd1;
      end
    end
  end

  assign stat_in  = stat_in_r;
  assign stat_out = stat_out_r;
`else
  assign stat_in  = 32'd0;
  assign stat_out = 32'd0;
`endif

endmodule

// File: tb/tb_rle_encoder.sv
// Self-checking bench for rle_encoder: per-cycle vector table plus
// scoreboard-checked multi-cycle sequences (saturation, alternation, reset).
module tb_rle_encoder;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       flush;
  logic [7:0] data_in;
  logic       valid_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       busy;
  logic [31:0] stat_in;
  logic [31:0] stat_out;

  int total;
  int bad;
  logic sb_en;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       en;
    logic       vin;
    logic       fl;
    logic [7:0] din;
    logic       exp_vout;
    logic [7:0] exp_dout;
    logic       exp_busy;
  } vec_t;

  vec_t vq[$];

  rle_encoder #(.SAMPLE_WIDTH(8)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .flush    (flush),
    .data_in  (data_in),
    .valid_in (valid_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .busy     (busy),
    .stat_in  (stat_in),
    .stat_out (stat_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic vin, input logic fl, input logic [7:0] din,
                     input logic ev, input logic [7:0] ed, input logic eb);
    vec_t v;
    v.en = en; v.vin = vin; v.fl = fl; v.din = din;
    v.exp_vout = ev; v.exp_dout = ed; v.exp_busy = eb;
    vq.push_back(v);
  endtask

  task automatic drive(input logic en, input logic vin, input logic [7:0] din, input logic fl);
    enable = en; valid_in = vin; data_in = din; flush = fl;
    @(negedge clock);
  endtask

  // scoreboard: every emitted word must match the oldest expected word
  always @(negedge clock) begin
    if (sb_en && reset_n && valid_out) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", {24'd0, data_out}, 32'hFFFF_FFFF);
      end else begin
        check("sb_word", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    total = 0; bad = 0; sb_en = 1'b0;
    reset_n = 1'b0; enable = 1'b0; flush = 1'b0; data_in = 8'h00; valid_in = 1'b0;

    // pass-through
    add(1'b0, 1'b1, 1'b0, 8'h12, 1'b1, 8'h12, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'h34, 1'b1, 8'h34, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    // short run 05 x4, 06, flush
    add(1'b1, 1'b1, 1'b0, 8'h05, 1'b1, 8'h05, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'h05, 1'b0, 8'h00, 1'b1);
    add(1'b1, 1'b1, 1'b0, 8'h05, 1'b0, 8'h00, 1'b1);
    add(1'b1, 1'b1, 1'b0, 8'h05, 1'b0, 8'h00, 1'b1);
    add(1'b1, 1'b1, 1'b0, 8'h06, 1'b1, 8'h83, 1'b1);
    add(1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h06, 1'b1);
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    // MSB masking
    add(1'b1, 1'b1, 1'b0, 8'h85, 1'b1, 8'h05, 1'b0);
    add(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    // flush together with a sample
    add(1'b1, 1'b1, 1'b0, 8'h05, 1'b1, 8'h05, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'h05, 1'b0, 8'h00, 1'b1);
    add(1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 8'h00, 1'b1);
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h82, 1'b0);
    // alternating values, no extra latency
    for (int i = 0; i < 6; i++) begin
      logic [7:0] a;
      a = (i % 2 == 0) ? 8'h01 : 8'h02;
      add(1'b1, 1'b1, 1'b0, a, 1'b1, a, 1'b0);
    end
    add(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    // pend conflict: count, then value clashes with pended value
    add(1'b1, 1'b1, 1'b0, 8'h07, 1'b1, 8'h07, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'h07, 1'b0, 8'h00, 1'b1);
    add(1'b1, 1'b1, 1'b0, 8'h09, 1'b1, 8'h81, 1'b1);
    add(1'b1, 1'b1, 1'b0, 8'h0A, 1'b1, 8'h09, 1'b1);
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h0A, 1'b0);
    add(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    // enable change drops the open run silently
    add(1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 8'h11, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 8'h00, 1'b1);
    add(1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 8'h22, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'h22, 1'b1, 8'h22, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    repeat (2) @(negedge clock);
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_valid_out", {31'd0, valid_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stat_in", stat_in, 32'd0);
    check("rst_stat_out", stat_out, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].en, vq[i].vin, vq[i].din, vq[i].fl);
      check($sformatf("vec%0d_valid_out", i), {31'd0, valid_out}, {31'd0, vq[i].exp_vout});
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vq[i].exp_busy});
      if (vq[i].exp_vout) begin
        check($sformatf("vec%0d_data_out", i), {24'd0, data_out}, {24'd0, vq[i].exp_dout});
      end
    end

    sb_en = 1'b1;
    // saturation: 130 x 05 -> 05, FF, 82
    for (int i = 0; i < 130; i++) begin
      if (i == 0) exp_q.push_back(8'h05);
      if (i == 128) exp_q.push_back(8'hFF);
      drive(1'b1, 1'b1, 8'h05, 1'b0);
    end
    exp_q.push_back(8'h82);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    repeat (4) drive(1'b1, 1'b0, 8'h00, 1'b0);
    check("sat_busy_after", {31'd0, busy}, 32'd0);
    check("sat_queue_drained", exp_q.size(), 32'd0);

    // alternating via scoreboard
    for (int i = 0; i < 6; i++) begin
      logic [7:0] a;
      a = (i % 2 == 0) ? 8'h01 : 8'h02;
      exp_q.push_back(a);
      drive(1'b1, 1'b1, a, 1'b0);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    repeat (3) drive(1'b1, 1'b0, 8'h00, 1'b0);
    check("alt_queue_drained", exp_q.size(), 32'd0);
    check("alt_busy_after", {31'd0, busy}, 32'd0);

    // reset in the middle of a run
    for (int i = 0; i < 50; i++) begin
      if (i == 0) exp_q.push_back(8'h05);
      drive(1'b1, 1'b1, 8'h05, 1'b0);
    end
    check("midrun_busy_before_reset", {31'd0, busy}, 32'd1);
    valid_in = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrun_rst_valid_out", {31'd0, valid_out}, 32'd0);
    check("midrun_rst_busy", {31'd0, busy}, 32'd0);
    check("midrun_rst_data_out", {24'd0, data_out}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    check("midrun_stat_in", stat_in, 32'd0);
    check("midrun_stat_out", stat_out, 32'd0);
    exp_q.push_back(8'h05);
    drive(1'b1, 1'b1, 8'h05, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    repeat (4) drive(1'b1, 1'b0, 8'h00, 1'b0);
    check("midrun_queue_drained", exp_q.size(), 32'd0);
    check("midrun_busy_after", {31'd0, busy}, 32'd0);

    sb_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rle_encoder.md
Name: rle_encoder

Overview:
Run-length encoder placed between the sampler and sample_fifo. Consumes the sampler's data/valid stream and writes a compressed word stream into the FIFO.
- In RLE mode, each run of identical samples becomes one value word, followed by one or more count words.
- With RLE off, samples pass through with one register of delay.
- The controller drives enable and flush; busy tells it when the stream has drained.

Parameters:
SAMPLE_WIDTH, 8, width of the sample and output word; must be >= 3.

Ports:
clock  in  1  system clock; all logic rising-edge.
reset_n  in  1  asynchronous active-low reset.
enable  in  1  1 = RLE mode, 0 = pass-through; sampled each cycle.
flush  in  1  single-cycle pulse: emit any outstanding count, then end the current run.
data_in  in  SAMPLE_WIDTH  sample from sampler.
valid_in  in  1  data_in qualifier, at most one sample per cycle.
data_out  out  SAMPLE_WIDTH  word to sample_fifo data_in.
valid_out  out  1  data_out qualifier, one word per cycle.
busy  out  1  pending word, outstanding count or deferred flush exists.
stat_in  out  32  input sample count; see Optional Feature.
stat_out  out  32  output word count; see Optional Feature.

Behaviour:
- Reset values: data_out = 0, valid_out = 0, busy = 0, stat_in = 0, stat_out = 0. Internal state is cleared: cnt = 0, last_valid = 0, pend_valid = 0, flush_pend = 0.
- Reset is effective immediately, including mid-run; no word is emitted for a run that reset interrupts.
- Word format in RLE mode (MSB = flag):
  - Value word: MSB = 0, low bits = data_in[SAMPLE_WIDTH-2:0]. data_in MSB is ignored.
  - Count word: MSB = 1, low bits = cnt, the number of repeats since the last value word or count word. cnt ranges 1..MAXC, where MAXC = 2^(SAMPLE_WIDTH-1) - 1.
  - Consecutive count words add up.
- Pass-through (enable = 0):
  - data_out <= data_in and valid_out <= valid_in, registered, latency 1.
  - RLE state is held cleared.
- A change of enable clears RLE state without emitting anything. The controller flushes and waits for busy = 0 before changing enable.
- Emission rule (RLE, only one word per cycle, all outputs registered). On valid_in:
  - New run (last_valid = 0): emit value word next cycle; last := sample; cnt := 0.
  - Repeat with cnt < MAXC: cnt := cnt + 1; nothing emitted.
  - Repeat with cnt == MAXC: emit count word MAXC; cnt := 1.
  - Change with cnt == 0: emit value word; last := sample.
  - Change with cnt > 0: emit count word cnt this cycle; new value word goes to the pend register and is emitted the next cycle; cnt := 0.
- Pend conflict: if pend_valid and a new sample would also emit, the pend word is emitted first and the new value word goes into pend.
  - Backlog never exceeds one word, because a count word only follows at least one idle output cycle.
  - A repeat of the pended value increments cnt normally.
- Flush:
  - flush sets flush_pend.
  - flush_pend is serviced in the first cycle with no sample-path or pend emission.
  - When serviced: if cnt > 0, emit count word cnt. Then cnt := 0, last_valid := 0, flush_pend := 0.
  - Flush arriving in the same cycle as valid_in: the sample is processed first and the flush is deferred.
  - Flush with cnt = 0 emits nothing.
- busy = pend_valid | flush_pend | (cnt != 0).
- No backpressure: the FIFO drops words when full (its own behaviour).

Optional Feature:
Macro RLE_STATS_EN.
- Defined: stat_in increments on each valid_in and stat_out on each valid_out, in both modes. Both wrap at 2^32 and clear on reset.
- Undefined: stat_in and stat_out are tied to 0 and no counter logic is generated.

Decomposition:
- Package acsp_pkg holds:
  - RLE_FLAG_BIT = SAMPLE_WIDTH-1
  - function rle_maxc(width)
  - enum rle_word_t {RLE_VALUE, RLE_COUNT}
- One sub-module, rle_run_counter: saturating cnt register with increment, load-1 and clear, and a sat flag (cnt == MAXC).

Test Plan:
- Pass-through: enable = 0; inputs 0x12, 0x34 on consecutive cycles -> data_out 0x12, 0x34 one cycle later; valid_out mirrors valid_in delayed 1.
- Short run: enable = 1; inputs 0x05, 0x05, 0x05, 0x05, 0x06, then flush.
  - Outputs: 0x05; then 0x83 in the 0x06 cycle +1; then 0x06 the next cycle.
  - Flush emits nothing; busy falls to 0.
- Saturation: 130 samples of 0x05, then flush -> 0x05, 0xFF, 0x82; busy = 0 afterwards.
- Alternating: 0x01, 0x02 every cycle for 6 cycles -> six value words in order, no count words, at most 1 cycle extra latency.
- Masking and simultaneous flush:
  - Input 0x85 -> value word 0x05.
  - 0x05, 0x05, then 0x05 with flush in the same cycle -> 0x05 then 0x82 on the next free cycle.
- Reset mid-run: 50 repeats of 0x05, then reset_n low -> valid_out 0 immediately. After release, sample 0x05 -> value word 0x05, no count word; stats are 0 before it.
